// File: rtl/wb_pwm_leds.sv
// Wishbone-classic LED peripheral: per-channel PWM brightness for green and RGB LEDs with shadowed duty.
// Optional build macro LEDS_FADE_EN: active duty ramps by one step per PWM period instead of jumping.
module wb_pwm_leds #(
    parameter int NUM_GREEN  = 4,
    parameter int NUM_RGB    = 4,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 64,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     cyc_i,
    input  logic                                     stb_i,
    input  logic                                     we_i,
    input  logic [ADDR_WIDTH-1:0]                    adr_i,
    input  logic [DATA_WIDTH-1:0]                    dat_i,
    output logic [DATA_WIDTH-1:0]                    dat_o,
    output logic                                     ack_o,
    output logic [NUM_GREEN-1:0]                     green_leds,
    output logic [((NUM_RGB > 0) ? 3*NUM_RGB : 1)-1:0] rgb_leds
);

    localparam int                  NCH      = NUM_GREEN + 3*NUM_RGB;
    localparam int                  PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PMAX     = '1;
    localparam logic [PWM_BITS-1:0] CNT_LAST = PMAX - PWM_BITS'(1);

    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_en;
    logic [PWM_BITS-1:0]   r_duty   [NCH];
    logic [PWM_BITS-1:0]   r_active [NCH];
    logic [PS_W-1:0]       r_presc;
    logic [PWM_BITS-1:0]   r_cnt;

    logic                  w_req;
    logic                  w_wr;
    logic                  w_ctrl_sel;
    logic                  w_tick;
    logic                  w_bound;
    logic                  w_busy;
    logic [NCH-1:0]        w_sel;
    logic [NCH-1:0]        w_out;
    logic [PWM_BITS-1:0]   w_duty_nxt [NCH];
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

`ifdef LEDS_FADE_EN
    function automatic logic [PWM_BITS-1:0] fade_step(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
        if (cur < tgt)      return cur + PWM_BITS'(1);
        else if (cur > tgt) return cur - PWM_BITS'(1);
        else                return cur;
    endfunction
`endif

    // A request is sampled once; the registered ack masks it for the following cycle.
    assign w_req      = cyc_i & stb_i & ~r_ack;
    assign w_wr       = w_req & we_i;
    assign w_ctrl_sel = (adr_i == '0);
    assign w_tick     = (r_presc == PS_LAST);
    assign w_bound    = w_tick & (r_cnt == CNT_LAST);
    assign w_unused   = ^dat_i;

    always_comb begin
        w_sel  = '0;
        w_busy = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            w_sel[k]      = (adr_i == ADDR_WIDTH'(k + 1));
            // A write landing on the boundary edge must be seen by the shadow update.
            w_duty_nxt[k] = (w_wr & w_sel[k]) ? dat_i[PWM_BITS-1:0] : r_duty[k];
            w_busy        = w_busy | (r_active[k] != r_duty[k]);
            w_out[k]      = r_en & (r_cnt < r_active[k]);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_ctrl_sel) begin
            w_rdata[0] = r_en;
            w_rdata[1] = w_busy;
        end
        for (int k = 0; k < NCH; k++) begin
            if (w_sel[k]) w_rdata[PWM_BITS-1:0] = r_duty[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_en  <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req & ~we_i) ? w_rdata : '0;
            if (w_wr & w_ctrl_sel) r_en <= dat_i[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NCH; k++) r_duty[k] <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_wr & w_sel[k]) r_duty[k] <= dat_i[PWM_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
            if (w_tick) r_cnt <= w_bound ? '0 : r_cnt + PWM_BITS'(1);
        end
    end

    // Shadow registers only move at a period boundary so no period is ever truncated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NCH; k++) r_active[k] <= '0;
        end else if (w_bound) begin
            for (int k = 0; k < NCH; k++) begin
`ifdef LEDS_FADE_EN
                r_active[k] <= fade_step(r_active[k], w_duty_nxt[k]);
`else
                r_active[k] <= w_duty_nxt[k];
`endif
            end
        end
    end

    assign ack_o      = r_ack;
    assign dat_o      = r_dat;
    assign green_leds = w_out[NUM_GREEN-1:0];

    generate
        if (NUM_RGB > 0) begin : g_rgb
            assign rgb_leds = w_out[NCH-1:NUM_GREEN];
        end else begin : g_no_rgb
            assign rgb_leds = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_wb_pwm_leds.sv
// Scoreboard bench for wb_pwm_leds: expected read data queued per access, checked when ack_o appears.
module tb_wb_pwm_leds;

    localparam int NG  = 4;
    localparam int NR  = 4;
    localparam int NCH = NG + 3*NR;
`ifdef LEDS_FADE_EN
    localparam int SETTLE = 260*255;
`else
    localparam int SETTLE = 300;
`endif

    typedef struct packed {
        logic        rd;
        logic [31:0] d;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cyc_i = 1'b0;
    logic          stb_i = 1'b0;
    logic          we_i = 1'b0;
    logic [7:0]    adr_i = '0;
    logic [31:0]   dat_i = '0;
    logic [31:0]   dat_o;
    logic          ack_o;
    logic [NG-1:0] green_leds;
    logic [3*NR-1:0] rgb_leds;
    logic [NCH-1:0]  leds;

    sb_t        sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         hi [NCH];
    logic       m_en = 1'b0;
    logic [7:0] m_duty [NCH];

    wb_pwm_leds #(
        .NUM_GREEN(NG), .NUM_RGB(NR), .PWM_BITS(8), .PRESCALE(1),
        .DATA_WIDTH(32), .ADDR_WIDTH(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
        .green_leds(green_leds), .rgb_leds(rgb_leds)
    );

    assign leds = {rgb_leds, green_leds};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        sb_t e;
        if (rst_ni) begin
            if (ack_o) begin
                if (sb.size() == 0) check("ack_unexpected", 32'(sb.size()), 1);
                else begin
                    e = sb.pop_front();
                    if (e.rd) check("rd_data", dat_o, e.d);
                end
            end else begin
                check("dat_idle", dat_o, 0);
            end
        end
    end

    task automatic xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
        int n;
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = a; dat_i = d;
        sb.push_back('{rd: ~we, d: exp});
        for (n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (ack_o) break;
        end
        check("ack_seen", 32'(ack_o), 1);
        check("ack_lat", 32'(n), 0);
        if (!ack_o) void'(sb.pop_back());
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        if (a == 0) m_en = d[0];
        else if (a <= NCH) m_duty[a-1] = d[7:0];
        xfer(1'b1, a, d, 0);
    endtask

    task automatic wb_read(input logic [7:0] a, input logic [31:0] exp);
        xfer(1'b0, a, 0, exp);
    endtask

    task automatic measure();
        for (int k = 0; k < NCH; k++) hi[k] = 0;
        repeat (255) begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) hi[k] += int'(leds[k]);
        end
    endtask

    task automatic wait_boundary();
        logic prev;
        bit   found = 0;
        @(negedge clk);
        prev = green_leds[0];
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!prev && green_leds[0]) begin found = 1; break; end
            prev = green_leds[0];
        end
        check("boundary_seen", 32'(found), 1);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int sum;
        for (int k = 0; k < NCH; k++) m_duty[k] = '0;

        // Request presented while reset is held: nothing may be acked or committed.
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'd0; dat_i = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack_o), 0);
        check("rst_dat", dat_o, 0);
        check("rst_leds", 32'(leds), 0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(negedge clk) rst_ni = 1'b1;

        wb_read(8'd0, 0);
        wb_read(8'd1, 0);
        wb_read(8'd16, 0);

        wb_write(8'd0, 32'd1);
        wb_write(8'd1, 32'd64);
        wb_write(8'd6, 32'd255);
        wb_write(8'd7, 32'd0);
        wb_write(8'd5, 32'h0000_0123);
        wb_read(8'd1, 64);
        wb_read(8'd6, 255);
        wb_read(8'd7, 0);
        wb_read(8'd5, 32'h23);

        repeat (SETTLE) @(posedge clk);
        measure();
        check("g0_duty64", 32'(hi[0]), 64);
        check("g1_off", 32'(hi[1]), 0);
        check("g3_off", 32'(hi[3]), 0);
        check("rgb0_duty35", 32'(hi[NG]), 35);
        check("rgb1_full", 32'(hi[NG+1]), 255);
        check("rgb2_zero", 32'(hi[NG+2]), 0);
        wb_read(8'd0, 1);

        // BUSY while the shadow lags the target.
        wait_boundary();
        wb_write(8'd3, 32'd10);
        wb_read(8'd0, 3);
`ifdef LEDS_FADE_EN
        for (int p = 1; p <= 10; p++) begin
            wait_boundary();
            wb_read(8'd0, (p < 10) ? 32'd3 : 32'd1);
        end
`else
        wait_boundary();
        wb_read(8'd0, 1);
`endif

        wb_read(8'h20, 0);
        wb_write(8'h20, 32'hFFFF_FFFF);
        wb_read(8'h11, 0);
        wb_write(8'h11, 32'h0000_00AA);
        for (int a = 0; a <= NCH; a++)
            wb_read(8'(a), (a == 0) ? {31'd0, m_en} : {24'd0, m_duty[a-1]});

        // Held request: ack must toggle rather than stay high.
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 8'd1;
        sb.push_back('{rd: 1'b1, d: 32'd64});
        sb.push_back('{rd: 1'b1, d: 32'd64});
        check("held_ack0", 32'(ack_o), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("held_ack_pat", 32'(ack_o), (i == 1) ? 32'd0 : 32'd1);
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        repeat (2) @(posedge clk);

        // Request withdrawn before the sampling edge.
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'd1; dat_i = 32'h99;
        @(negedge clk);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        check("drop_no_ack", 32'(ack_o), 0);
        wb_read(8'd1, 64);

        wb_write(8'd0, 32'd0);
        measure();
        sum = 0;
        for (int k = 0; k < NCH; k++) sum += hi[k];
        check("en0_all_off", 32'(sum), 0);
        wb_read(8'd0, 0);

        wb_write(8'd0, 32'd1);
        repeat (2) @(negedge clk);
        check("rgb1_on_pre_rst", 32'(rgb_leds[1]), 1);

        // Asynchronous reset asserted together with a write strobe.
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'd1; dat_i = 32'd200;
        rst_ni = 1'b0;
        #1;
        check("async_rst_leds", 32'(leds), 0);
        @(posedge clk); #1;
        check("async_rst_ack", 32'(ack_o), 0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(negedge clk) rst_ni = 1'b1;
        m_en = 1'b0;
        for (int k = 0; k < NCH; k++) m_duty[k] = '0;
        wb_read(8'd0, 0);
        wb_read(8'd1, 0);
        wb_read(8'd6, 0);
        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
